datapath_core: RTL and testbench
================================

// Module: datapath_core
// PURPOSE
//  Execution datapath for the 16-bit fetch/decode/execute processor: 16x16 register file + ALU with flags,
//  program counter with conditional jumps, and a 256x16 data RAM, joined by one internal data bus.
//  The controller FSM drives the opcode/operand words and per-unit enables.
//  Fetched ROM data enters on data_in; the bus value is exported on data_out.
// PARAMETERS
//  DATA_WIDTH  16   bus, register, RAM word and PC width
//  REG_COUNT   16   register-file entries (index = 4 bits)
//  RAM_DEPTH   256  RAM words (address = 8 bits)
// PORTS
//  clk               in   1   system clock, rising edge
//  reset             in   1   asynchronous, active-low reset (0 = reset)
//  opcode            in   16  current instruction opcode word
//  operand           in   16  current instruction operand word
//  data_in           in   16  external bus source (ROM data); default bus driver
//  alu_read_enable   in   1   drive register value onto bus
//  alu_write_enable  in   1   write register file (ALU result or bus)
//  ram_read_enable   in   1   drive RAM word onto bus
//  ram_write_enable  in   1   write RAM word
//  pc_read_enable    in   1   drive PC onto bus
//  pc_enable         in   1   advance/jump PC this cycle
//  data_out          out  16  internal bus value
//  data_valid        out  1   1 when any read enable is high
//  alu_flags         out  4   {V,N,C,Z} = [3:0]
//  pc_debug          out  16  current PC
// BEHAVIOUR
//  Reset (reset=0, async): PC=0, all registers=0, flags=0, all RAM words=0. data_out follows bus (=data_in).
//  Bus (combinational): alu_read ? reg[opcode[3:0]] : ram_read ? ram[addr] : pc_read ? PC : data_in.
//   Priority ALU > RAM > PC when several read enables are high. Reads return pre-edge values.
//  RAM addr = operand[7:0] when opcode[15:12]==4'h9, else opcode[7:0]. Async read; sync write.
//  RAM write (ram_write_enable, rising edge): data = operand if opcode[15:8]==8'h41 (immediate),
//   else bus (8'h31 ROM->RAM uses data_in; 8'h91 REG->RAM uses reg[opcode[3:0]] with alu_read_enable).
//  Register write (alu_write_enable, rising edge):
//   opcode[15:12]==4'h1: ALU op; fn=opcode[11:8], rd=opcode[7:4], A=reg[opcode[3:0]], B=reg[operand[3:0]].
//    fn 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical), 8 MOV A, 9 LDI operand.
//    fn 10-15: no register or flag change.
//    Flags updated for fn 0-9: Z=(result==0), N=result[15].
//    C: ADD = bit16 of 17-bit sum; SUB = borrow (A<B unsigned); SHL = old A[15]; SHR = old A[0]; others 0.
//    V: signed overflow for ADD/SUB; others 0.
//   opcode[15:8]==8'h92: reg[opcode[3:0]] <= bus (RAM->REG, with ram_read_enable). Flags unchanged.
//   Any other opcode: ignored. Result truncated to 16 bits.
//  PC (pc_enable, rising edge):
//   If opcode[15:12]==4'h7: cond=opcode[11:8]: 0 always, 1 Z, 2 !Z, 3 C, 4 N; other cond codes never taken.
//   Taken -> PC<=operand; else PC<=PC+1. Non-jump opcode -> PC<=PC+1. 0xFFFF+1 wraps to 0x0000.
//   Jump condition uses flags as held before the edge.
//  Simultaneous events: reg write and read of same index -> bus shows old value; new value next cycle.
//   pc_enable and other enables in same cycle act independently.
//  reset asserted mid-operation: immediate clear, pending writes dropped; resumes on first edge after release.
// TESTING
//  Reset: hold reset=0 with random enables -> pc_debug=0, alu_flags=0, data_valid=0, data_out=data_in.
//  LDI r1=0xFFFF (0x1910), LDI r2=0x0001 (0x1920), ADD r3=r1+r2 (0x1031, operand 2) -> flags Z=1,C=1.
//   Then read 0x2203 -> data_out=0x0000.
//  SUB r4=r2-r1 (0x1142, operand 1) -> r4=0x0002, C=1 (borrow), Z=0.
//  Imm->RAM: 0x4110, operand 0xBEEF -> RAM[0x10]=0xBEEF; read 0x4210 -> data_out=0xBEEF.
//   0x9205, operand 0x0010 with ram_read+alu_write -> r5=0xBEEF.
//   0x9105, operand 0x0020 with alu_read+ram_write -> RAM[0x20]=0xBEEF.
//  PC: 3 pulses of pc_enable (non-jump) -> 3.
//   JZ 0x7100 op 0x0040 with Z=1 -> 0x0040; JNZ 0x7200 with Z=1 -> 0x0041.
//   Unconditional 0x7000 op 0xFFFF, then one more advance -> 0x0000.
//  Async reset mid-cycle (between edges) during ADD -> regs/flags/PC clear at once; no write after release.

Source files
------------

// File: rtl/datapath_core.sv
`default_nettype none
// ============================================================================
// Module      : datapath_core
// Description : Execution datapath of the 16-bit fetch/decode/execute CPU.
//               A 16x16 register file with flag-producing ALU, a program
//               counter with conditional jumps and a 256x16 data RAM share
//               one internal data bus. The controller supplies the opcode
//               and operand words plus per-unit enables.
// Ports       : clk               - system clock, rising edge
//               reset             - asynchronous reset, active low
//               opcode / operand  - current instruction words
//               data_in           - ROM data, default bus driver
//               alu_read_enable   - register -> bus
//               alu_write_enable  - register file write (ALU result or bus)
//               ram_read_enable   - RAM -> bus
//               ram_write_enable  - RAM write
//               pc_read_enable    - PC -> bus
//               pc_enable         - advance / jump PC
//               data_out          - internal bus value
//               data_valid        - a read enable is driving the bus
//               alu_flags         - {V,N,C,Z}
//               pc_debug          - current PC
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_core #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 16,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0] operand,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  alu_read_enable,
    input  logic                  alu_write_enable,
    input  logic                  ram_read_enable,
    input  logic                  ram_write_enable,
    input  logic                  pc_read_enable,
    input  logic                  pc_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [3:0]            alu_flags,
    output logic [DATA_WIDTH-1:0] pc_debug
);

    localparam int REG_AW = $clog2(REG_COUNT);
    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int MSB    = DATA_WIDTH - 1;

    localparam logic [3:0] C_OP_ALU    = 4'h1;
    localparam logic [3:0] C_OP_JMP    = 4'h7;
    localparam logic [3:0] C_OP_RAMOPD = 4'h9;
    localparam logic [7:0] C_OP_IMMRAM = 8'h41;
    localparam logic [7:0] C_OP_RAMREG = 8'h92;

    // Flag bit positions inside flags_q
    localparam int C_FV = 3;
    localparam int C_FN = 2;
    localparam int C_FC = 1;
    localparam int C_FZ = 0;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] ram_q  [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]            flags_q, flags_d;

    // ------------------------------------------------------------------
    // Bus. Reads are gated by reset so that while reset is held the bus
    // simply mirrors data_in and data_valid stays low.
    // ------------------------------------------------------------------
    logic                  w_alu_rd, w_ram_rd, w_pc_rd;
    logic [RAM_AW-1:0]     w_ram_addr;
    logic [DATA_WIDTH-1:0] w_bus;

    assign w_alu_rd = alu_read_enable & reset;
    assign w_ram_rd = ram_read_enable & reset;
    assign w_pc_rd  = pc_read_enable  & reset;

    assign w_ram_addr = (opcode[15:12] == C_OP_RAMOPD) ? operand[RAM_AW-1:0]
                                                       : opcode[RAM_AW-1:0];

    always_comb begin
        w_bus = data_in;
        if (w_alu_rd)
            w_bus = regs_q[opcode[REG_AW-1:0]];
        else if (w_ram_rd)
            w_bus = ram_q[w_ram_addr];
        else if (w_pc_rd)
            w_bus = pc_q;
    end

    assign data_out   = w_bus;
    assign data_valid = w_alu_rd | w_ram_rd | w_pc_rd;
    assign alu_flags  = flags_q;
    assign pc_debug   = pc_q;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_a, w_b, w_res;
    logic [DATA_WIDTH:0]   w_sum, w_diff;
    logic [3:0]            w_fn;
    logic                  w_c, w_v, w_alu_fn_ok;

    assign w_a    = regs_q[opcode[REG_AW-1:0]];
    assign w_b    = regs_q[operand[REG_AW-1:0]];
    assign w_fn   = opcode[11:8];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    // Top bit of the zero-extended difference is the unsigned borrow.
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_res       = '0;
        w_c         = 1'b0;
        w_v         = 1'b0;
        w_alu_fn_ok = 1'b1;
        case (w_fn)
            4'd0: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[DATA_WIDTH];
                w_v   = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
            end
            4'd1: begin
                w_res = w_diff[MSB:0];
                w_c   = w_diff[DATA_WIDTH];
                w_v   = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
            end
            4'd2: w_res = w_a & w_b;
            4'd3: w_res = w_a | w_b;
            4'd4: w_res = w_a ^ w_b;
            4'd5: w_res = ~w_a;
            4'd6: begin
                w_res = {w_a[MSB-1:0], 1'b0};
                w_c   = w_a[MSB];
            end
            4'd7: begin
                w_res = {1'b0, w_a[MSB:1]};
                w_c   = w_a[0];
            end
            4'd8: w_res = w_a;
            4'd9: w_res = operand;
            default: w_alu_fn_ok = 1'b0;
        endcase
    end

    always_comb begin
        flags_d       = '0;
        flags_d[C_FV] = w_v;
        flags_d[C_FN] = w_res[MSB];
        flags_d[C_FC] = w_c;
        flags_d[C_FZ] = (w_res == '0);
    end

    // ------------------------------------------------------------------
    // Register file write control
    // ------------------------------------------------------------------
    logic                  w_is_alu, w_is_ramreg, w_reg_we, w_flags_we;
    logic [REG_AW-1:0]     w_reg_waddr;
    logic [DATA_WIDTH-1:0] w_reg_wdata;

    assign w_is_alu    = (opcode[15:12] == C_OP_ALU) && w_alu_fn_ok;
    assign w_is_ramreg = (opcode[15:8] == C_OP_RAMREG);
    assign w_flags_we  = alu_write_enable && w_is_alu;
    assign w_reg_we    = alu_write_enable && (w_is_alu || w_is_ramreg);
    assign w_reg_waddr = w_is_alu ? opcode[7:4] : opcode[REG_AW-1:0];
    assign w_reg_wdata = w_is_alu ? w_res : w_bus;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs_q[i] <= '0;
            flags_q <= '0;
        end else begin
            if (w_reg_we)
                regs_q[w_reg_waddr] <= w_reg_wdata;
            if (w_flags_we)
                flags_q <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Data RAM: immediate stores take the operand, everything else the bus
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_ram_wdata;

    assign w_ram_wdata = (opcode[15:8] == C_OP_IMMRAM) ? operand : w_bus;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAM_DEPTH; i++)
                ram_q[i] <= '0;
        end else if (ram_write_enable) begin
            ram_q[w_ram_addr] <= w_ram_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Program counter; jump conditions look at the pre-edge flags.
    // ------------------------------------------------------------------
    logic w_taken;

    always_comb begin
        w_taken = 1'b0;
        if (opcode[15:12] == C_OP_JMP) begin
            case (opcode[11:8])
                4'd0:    w_taken = 1'b1;
                4'd1:    w_taken = flags_q[C_FZ];
                4'd2:    w_taken = !flags_q[C_FZ];
                4'd3:    w_taken = flags_q[C_FC];
                4'd4:    w_taken = flags_q[C_FN];
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_enable)
            pc_d = w_taken ? operand : pc_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_core
// Description : Self-checking bench for datapath_core. A behavioural model
//               (plain integer arithmetic over arrays) predicts bus, PC and
//               flags each cycle; directed sequences cover the documented
//               scenarios, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_core;

    localparam logic [5:0] E_ALU_RD = 6'b000001;
    localparam logic [5:0] E_ALU_WR = 6'b000010;
    localparam logic [5:0] E_RAM_RD = 6'b000100;
    localparam logic [5:0] E_RAM_WR = 6'b001000;
    localparam logic [5:0] E_PC_RD  = 6'b010000;
    localparam logic [5:0] E_PC_EN  = 6'b100000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] opcode, operand, data_in;
    logic        alu_read_enable, alu_write_enable;
    logic        ram_read_enable, ram_write_enable;
    logic        pc_read_enable, pc_enable;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  alu_flags;
    logic [15:0] pc_debug;

    always #5 clk = ~clk;

    datapath_core dut (
        .clk              (clk),
        .reset            (reset),
        .opcode           (opcode),
        .operand          (operand),
        .data_in          (data_in),
        .alu_read_enable  (alu_read_enable),
        .alu_write_enable (alu_write_enable),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .pc_read_enable   (pc_read_enable),
        .pc_enable        (pc_enable),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .alu_flags        (alu_flags),
        .pc_debug         (pc_debug)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [15:0] m_reg [16];
    logic [15:0] m_ram [256];
    logic [15:0] m_pc;
    bit          mZ, mC, mN, mV;
    logic [15:0] last_bus;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++)  m_reg[i] = 16'h0;
        for (int i = 0; i < 256; i++) m_ram[i] = 16'h0;
        m_pc = 16'h0;
        mZ = 0; mC = 0; mN = 0; mV = 0;
    endfunction

    function automatic logic [15:0] m_flags();
        return {12'h0, mV, mN, mC, mZ};
    endfunction

    function automatic int m_addr(input logic [15:0] op, input logic [15:0] opr);
        return (op[15:12] == 4'h9) ? int'(opr[7:0]) : int'(op[7:0]);
    endfunction

    function automatic logic [15:0] model_bus(input logic [15:0] op, input logic [15:0] opr,
                                              input logic [15:0] din, input logic [5:0] en,
                                              input logic rst_v);
        if (!rst_v)  return din;
        if (en[0])   return m_reg[op[3:0]];
        if (en[2])   return m_ram[m_addr(op, opr)];
        if (en[4])   return m_pc;
        return din;
    endfunction

    // One rising edge worth of architectural effects, from pre-edge state.
    function automatic void model_step(input logic [15:0] op, input logic [15:0] opr,
                                       input logic [5:0] en, input logic [15:0] bus);
        bit          taken = 0;
        int          ua, ub, sa, sb, res, sres;
        bit          c, v;
        logic [15:0] r16;
        int          fn;
        if (op[15:12] == 4'h7) begin
            case (int'(op[11:8]))
                0: taken = 1;
                1: taken = mZ;
                2: taken = !mZ;
                3: taken = mC;
                4: taken = mN;
                default: taken = 0;
            endcase
        end
        if (en[1]) begin
            fn = int'(op[11:8]);
            if (op[15:12] == 4'h1 && fn <= 9) begin
                ua = int'(m_reg[op[3:0]]);
                ub = int'(m_reg[opr[3:0]]);
                sa = (ua >= 32768) ? ua - 65536 : ua;
                sb = (ub >= 32768) ? ub - 65536 : ub;
                c = 0; v = 0; res = 0;
                case (fn)
                    0: begin res = ua + ub; c = (res > 65535); sres = sa + sb;
                             v = (sres > 32767) || (sres < -32768); end
                    1: begin res = ua - ub; c = (ua < ub); sres = sa - sb;
                             v = (sres > 32767) || (sres < -32768); end
                    2: res = ua & ub;
                    3: res = ua | ub;
                    4: res = ua ^ ub;
                    5: res = 65535 - ua;
                    6: begin res = ua * 2; c = (ua >= 32768); end
                    7: begin res = ua / 2; c = (ua % 2) == 1; end
                    8: res = ua;
                    default: res = int'(opr);
                endcase
                r16 = res[15:0];
                m_reg[op[7:4]] = r16;
                mZ = (r16 == 16'h0); mN = r16[15]; mC = c; mV = v;
            end else if (op[15:8] == 8'h92) begin
                m_reg[op[3:0]] = bus;
            end
        end
        if (en[3])
            m_ram[m_addr(op, opr)] = (op[15:8] == 8'h41) ? opr : bus;
        if (en[5])
            m_pc = taken ? opr : m_pc + 16'd1;
    endfunction

    task automatic drive(input logic [15:0] op, input logic [15:0] opr,
                         input logic [15:0] din, input logic [5:0] en, input logic rst_v);
        opcode           = op;
        operand          = opr;
        data_in          = din;
        alu_read_enable  = en[0];
        alu_write_enable = en[1];
        ram_read_enable  = en[2];
        ram_write_enable = en[3];
        pc_read_enable   = en[4];
        pc_enable        = en[5];
        reset            = rst_v;
    endtask

    // Drive at the falling edge, check combinational bus, clock, check state.
    task automatic cyc(input logic [15:0] op, input logic [15:0] opr,
                       input logic [15:0] din, input logic [5:0] en, input logic rst_v);
        logic [15:0] exp_bus;
        @(negedge clk);
        drive(op, opr, din, en, rst_v);
        if (!rst_v) model_reset();
        #1;
        exp_bus  = model_bus(op, opr, din, en, rst_v);
        last_bus = data_out;
        check("bus", data_out, exp_bus);
        check("valid", {15'h0, data_valid}, {15'h0, rst_v && (en[0] || en[2] || en[4])});
        @(posedge clk);
        if (rst_v) model_step(op, opr, en, exp_bus);
        #1;
        check("pc", pc_debug, m_pc);
        check("flags", {12'h0, alu_flags}, m_flags());
    endtask

    initial begin
        logic [15:0] rop;
        drive(16'h0, 16'h0, 16'h0, 6'h0, 1'b0);
        model_reset();

        // Reset held with random enables
        for (int i = 0; i < 4; i++)
            cyc(16'($urandom), 16'($urandom), 16'($urandom), 6'($urandom), 1'b0);
        check("rst_pc", pc_debug, 16'h0000);
        check("rst_flags", {12'h0, alu_flags}, 16'h0000);

        // ALU sequence
        cyc(16'h1910, 16'hFFFF, 16'h0, E_ALU_WR, 1'b1);
        cyc(16'h1920, 16'h0001, 16'h0, E_ALU_WR, 1'b1);
        cyc(16'h1031, 16'h0002, 16'h0, E_ALU_WR, 1'b1);
        check("add_flags", {12'h0, alu_flags}, 16'h0003);
        cyc(16'h2203, 16'h0000, 16'h1234, E_ALU_RD, 1'b1);
        check("add_r3", last_bus, 16'h0000);
        cyc(16'h1142, 16'h0001, 16'h0, E_ALU_WR, 1'b1);
        check("sub_flags", {12'h0, alu_flags}, 16'h0002);
        cyc(16'h2204, 16'h0000, 16'h0, E_ALU_RD, 1'b1);
        check("sub_r4", last_bus, 16'h0002);

        // RAM paths
        cyc(16'h4110, 16'hBEEF, 16'h0, E_RAM_WR, 1'b1);
        cyc(16'h4210, 16'h0000, 16'h0, E_RAM_RD, 1'b1);
        check("imm_ram", last_bus, 16'hBEEF);
        cyc(16'h9205, 16'h0010, 16'h0, E_RAM_RD | E_ALU_WR, 1'b1);
        cyc(16'h2205, 16'h0000, 16'h0, E_ALU_RD, 1'b1);
        check("ram_to_r5", last_bus, 16'hBEEF);
        cyc(16'h9105, 16'h0020, 16'h0, E_ALU_RD | E_RAM_WR, 1'b1);
        cyc(16'h4220, 16'h0000, 16'h0, E_RAM_RD, 1'b1);
        check("r5_to_ram", last_bus, 16'hBEEF);
        cyc(16'h3130, 16'h0000, 16'hCAFE, E_RAM_WR, 1'b1);
        cyc(16'h4230, 16'h0000, 16'h0, E_RAM_RD, 1'b1);
        check("rom_to_ram", last_bus, 16'hCAFE);

        // PC advance and jumps
        repeat (3) cyc(16'h0000, 16'h0000, 16'h0, E_PC_EN, 1'b1);
        check("pc_adv3", pc_debug, 16'h0003);
        cyc(16'h1031, 16'h0002, 16'h0, E_ALU_WR, 1'b1);
        cyc(16'h7100, 16'h0040, 16'h0, E_PC_EN, 1'b1);
        check("jz_taken", pc_debug, 16'h0040);
        cyc(16'h7200, 16'h1234, 16'h0, E_PC_EN, 1'b1);
        check("jnz_not", pc_debug, 16'h0041);
        cyc(16'h7000, 16'hFFFF, 16'h0, E_PC_EN, 1'b1);
        check("jmp", pc_debug, 16'hFFFF);
        cyc(16'h0000, 16'h0000, 16'h0, E_PC_EN, 1'b1);
        check("pc_wrap", pc_debug, 16'h0000);

        // Read priority, read-during-write of the same register
        cyc(16'h2201, 16'h0000, 16'h0, E_ALU_RD | E_RAM_RD | E_PC_RD | E_PC_EN, 1'b1);
        check("prio", last_bus, 16'hFFFF);
        cyc(16'h1911, 16'h5555, 16'h0, E_ALU_RD | E_ALU_WR | E_PC_EN, 1'b1);
        check("rdw_old", last_bus, 16'hFFFF);
        cyc(16'h2201, 16'h0000, 16'h0, E_ALU_RD, 1'b1);
        check("rdw_new", last_bus, 16'h5555);

        // Async reset between edges during an ADD
        @(negedge clk);
        drive(16'h1031, 16'h0002, 16'h0, E_ALU_WR | E_PC_EN, 1'b1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_pc", pc_debug, 16'h0000);
        check("async_flags", {12'h0, alu_flags}, 16'h0000);
        @(posedge clk);
        #1;
        drive(16'h1031, 16'h0002, 16'h0, 6'h0, 1'b0);
        #1;
        reset = 1'b1;
        check("held_pc", pc_debug, 16'h0000);
        cyc(16'h2201, 16'h0000, 16'h0, E_ALU_RD, 1'b1);
        check("async_r1", last_bus, 16'h0000);
        cyc(16'h2203, 16'h0000, 16'h0, E_ALU_RD, 1'b1);
        check("async_r3", last_bus, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 6))
                0, 1:    rop = {4'h1, 4'($urandom_range(0, 11)), 8'($urandom)};
                2:       rop = {8'h92, 8'($urandom)};
                3:       rop = {8'h91, 8'($urandom)};
                4:       rop = {8'h41, 8'($urandom)};
                5:       rop = {4'h7, 4'($urandom_range(0, 5)), 8'($urandom)};
                default: rop = 16'($urandom);
            endcase
            cyc(rop, 16'($urandom), 16'($urandom), 6'($urandom),
                ($urandom_range(0, 39) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
